// File: rtl/dco_pkg.sv
// Shared definitions for the DCO and its period meter: the coarse level
// table that maps each 4-bit level to its toggle period, plus meter FSM states.
package dco_pkg;

  localparam int NUM_LEVELS = 16;

  // Toggle period (P) of each coarse level; the DCO toggles every P+1 clk cycles.
  localparam logic [7:0] LEVEL_PERIOD [0:NUM_LEVELS-1] = '{
    8'd10, 8'd30, 8'd34, 8'd40, 8'd44, 8'd50, 8'd54, 8'd60,
    8'd64, 8'd70, 8'd74, 8'd80, 8'd84, 8'd90, 8'd94, 8'd100
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

endpackage

// File: rtl/dco_level_encoder.sv
// Maps a measured half-period H to the nearest coarse level (P = H-1).
// Ties resolve to the lower level because only a strictly smaller distance wins.
module dco_level_encoder
  import dco_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic [CNT_W-1:0] i_half,
  output logic [3:0]       o_level
);

  // One spare bit so the all-ones initial best distance is never matched.
  localparam int DW = ((CNT_W > 8) ? CNT_W : 8) + 1;

  logic [CNT_W-1:0] w_p;
  logic [DW-1:0]    w_p_ext;
  logic [DW-1:0]    w_entry;
  logic [DW-1:0]    w_dist;
  logic [DW-1:0]    w_best_dist;

  assign w_p = i_half - CNT_W'(1);

  always_comb begin
    w_p_ext     = DW'(w_p);
    w_entry     = '0;
    w_dist      = '0;
    w_best_dist = '1;
    o_level     = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      w_entry = DW'(LEVEL_PERIOD[i]);
      w_dist  = (w_p_ext >= w_entry) ? (w_p_ext - w_entry) : (w_entry - w_p_ext);
      if (w_dist < w_best_dist) begin
        w_best_dist = w_dist;
        o_level     = 4'(i);
      end
    end
  end

endmodule

// File: rtl/dco_period_meter.sv
// Measures DCO half-periods in clk cycles, converts them to the nearest coarse
// level, and tracks measurement stability and loss of toggling.
//
// meas_valid is a single-cycle qualifier with no back-pressure: half_period,
// level and stable are meaningful on the cycle it is high, and the consumer
// must take them then (half_period/level also hold until the next pulse).
module dco_period_meter
  import dco_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int TIMEOUT  = 255,
  parameter int STABLE_N = 4,
  parameter int TOL      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dco_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] half_period,
  output logic [3:0]       level,
  output logic             stable,
  output logic             timeout,
  output state_t           dbg_state
);

  localparam int               RUN_W     = $clog2(STABLE_N + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W:0]   TOL_V     = (CNT_W + 1)'(TOL);
  localparam logic [RUN_W-1:0] STABLE_V  = RUN_W'(STABLE_N);

  state_t           r_state, w_state_n;
  logic             r_sync1, r_sync2, r_prev;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [CNT_W-1:0] r_half, w_half_n;
  logic [3:0]       r_level, w_level_n;
  logic             r_valid, w_valid_n;
  logic             r_stable, w_stable_n;
  logic             r_timeout, w_timeout_n;
  logic [RUN_W-1:0] r_run, w_run_n;

  logic                    w_edge;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic signed [CNT_W:0]   w_diff;
  logic [CNT_W:0]          w_abs;
  logic                    w_in_tol;
  logic [3:0]              w_enc_level;

  // dco_in is asynchronous: two-flop synchronizer, then one more stage for edge detect.
  assign w_edge    = r_sync2 ^ r_prev;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_W'(1));
  assign w_diff    = $signed({1'b0, r_cnt}) - $signed({1'b0, r_half});
  assign w_abs     = w_diff[CNT_W] ? (-w_diff) : w_diff;
  assign w_in_tol  = (w_abs <= TOL_V);

  dco_level_encoder #(
    .CNT_W (CNT_W)
  ) u_enc (
    .i_half  (r_cnt),
    .o_level (w_enc_level)
  );

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_half_n    = r_half;
    w_level_n   = r_level;
    w_valid_n   = 1'b0;
    w_stable_n  = r_stable;
    w_timeout_n = r_timeout;
    w_run_n     = r_run;

    if (!en) begin
      w_state_n   = IDLE;
      w_cnt_n     = '0;
      w_stable_n  = 1'b0;
      w_timeout_n = 1'b0;
      w_run_n     = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_n = ARM;
          w_cnt_n   = '0;
        end
        ARM: begin
          w_cnt_n = '0;
          if (w_edge) begin
            w_cnt_n   = CNT_W'(1);
            w_state_n = MEASURE;
          end
        end
        MEASURE: begin
          // An edge on the timeout cycle still counts as a measurement.
          if (w_edge) begin
            w_half_n    = r_cnt;
            w_level_n   = w_enc_level;
            w_valid_n   = 1'b1;
            w_timeout_n = 1'b0;
            w_cnt_n     = CNT_W'(1);
            if (r_run == '0) begin
              w_run_n = RUN_W'(1);
            end else if (w_in_tol) begin
              w_run_n = (r_run >= STABLE_V) ? STABLE_V : (r_run + RUN_W'(1));
            end else begin
              w_run_n = RUN_W'(1);
            end
            w_stable_n = (w_run_n >= STABLE_V);
          end else if (r_cnt >= TIMEOUT_V) begin
            w_timeout_n = 1'b1;
            w_stable_n  = 1'b0;
            w_run_n     = '0;
            w_cnt_n     = '0;
            w_state_n   = ARM;
          end else begin
            w_cnt_n = w_cnt_inc;
          end
        end
        default: begin
          w_state_n = IDLE;
          w_cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_prev    <= 1'b0;
      r_cnt     <= '0;
      r_half    <= '0;
      r_level   <= '0;
      r_valid   <= 1'b0;
      r_stable  <= 1'b0;
      r_timeout <= 1'b0;
      r_run     <= '0;
    end else begin
      r_state   <= w_state_n;
      r_sync1   <= dco_in;
      r_sync2   <= r_sync1;
      r_prev    <= r_sync2;
      r_cnt     <= w_cnt_n;
      r_half    <= w_half_n;
      r_level   <= w_level_n;
      r_valid   <= w_valid_n;
      r_stable  <= w_stable_n;
      r_timeout <= w_timeout_n;
      r_run     <= w_run_n;
    end
  end

  assign meas_valid  = r_valid;
  assign half_period = r_half;
  assign level       = r_level;
  assign stable      = r_stable;
  assign timeout     = r_timeout;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_dco_period_meter.sv
// Directed bench for dco_period_meter: dco_in is toggled with hand-chosen gaps
// and each resulting measurement is compared with hand-computed values.
module tb_dco_period_meter;
  import dco_pkg::*;

  localparam int CNT_W    = 8;
  localparam int TIMEOUT  = 255;
  localparam int STABLE_N = 4;
  localparam int TOL      = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             dco_in;
  logic             meas_valid;
  logic [CNT_W-1:0] half_period;
  logic [3:0]       level;
  logic             stable;
  logic             timeout;
  state_t           dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  dco_period_meter #(
    .CNT_W    (CNT_W),
    .TIMEOUT  (TIMEOUT),
    .STABLE_N (STABLE_N),
    .TOL      (TOL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .dco_in      (dco_in),
    .meas_valid  (meas_valid),
    .half_period (half_period),
    .level       (level),
    .stable      (stable),
    .timeout     (timeout),
    .dbg_state   (dbg_state)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called #1 after a posedge. Toggles dco_in, then spends n cycles. The pulse
  // for this toggle appears 3 cycles later and carries the PREVIOUS gap as H.
  task automatic toggle_gap(input int n, input bit chk, input int eh, input int el,
                            input bit es, input bit et);
    dco_in = ~dco_in;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      if (c == 3) begin
        check_val("meas_valid", meas_valid, chk);
        check_val("timeout", timeout, et);
        if (chk) begin
          check_val("half_period", half_period, eh);
          check_val("level", level, el);
          check_val("stable", stable, es);
        end
      end
      if (c == 4) check_val("pulse_width", meas_valid, 0);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_valid"}, meas_valid, 0);
    check_val({tag, "_half"}, half_period, 0);
    check_val({tag, "_level"}, level, 0);
    check_val({tag, "_stable"}, stable, 0);
    check_val({tag, "_timeout"}, timeout, 0);
    check_val({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    dco_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero("post_reset");
    en = 1'b1;
    @(posedge clk); #1;
    check_val("arm_state", 32'(dbg_state), 32'(ARM));

    // Steady period 50: toggles every 51 cycles, stable on the 4th pulse.
    toggle_gap(51, 0, 0, 0, 0, 0);
    toggle_gap(51, 1, 51, 5, 0, 0);
    toggle_gap(51, 1, 51, 5, 0, 0);
    toggle_gap(51, 1, 51, 5, 0, 0);
    toggle_gap(51, 1, 51, 5, 1, 0);

    // Ties and extremes: 33 ties 30/34 -> 1, 200 -> 15, 95 -> 14, 1 -> 0.
    toggle_gap(33, 1, 51, 5, 1, 0);
    toggle_gap(200, 1, 33, 1, 0, 0);
    toggle_gap(95, 1, 200, 15, 0, 0);
    toggle_gap(40, 1, 95, 14, 0, 0);
    toggle_gap(1, 0, 0, 0, 0, 0);
    toggle_gap(51, 1, 1, 0, 0, 0);

    // Re-stabilise at 51, then stop toggling.
    toggle_gap(51, 1, 51, 5, 0, 0);
    toggle_gap(51, 1, 51, 5, 0, 0);
    toggle_gap(51, 1, 51, 5, 0, 0);
    toggle_gap(40, 1, 51, 5, 1, 0);
    for (int c = 41; c <= 258; c++) begin
      @(posedge clk); #1;
      if (c == 257) begin
        check_val("timeout_early", timeout, 0);
        check_val("stable_before_to", stable, 1);
      end
      if (c == 258) begin
        check_val("timeout_set", timeout, 1);
        check_val("stable_after_to", stable, 0);
        check_val("to_state", 32'(dbg_state), 32'(ARM));
      end
    end

    // Resume, then jitter 51,52,51,53 and a 53 run reaching stable.
    toggle_gap(51, 0, 0, 0, 0, 1);
    toggle_gap(52, 1, 51, 5, 0, 0);
    toggle_gap(51, 1, 52, 5, 0, 0);
    toggle_gap(53, 1, 51, 5, 0, 0);
    toggle_gap(53, 1, 53, 5, 0, 0);
    toggle_gap(53, 1, 53, 5, 0, 0);
    toggle_gap(53, 1, 53, 5, 0, 0);
    toggle_gap(40, 1, 53, 5, 1, 0);

    // Drop en mid-measurement.
    en = 1'b0;
    @(posedge clk); #1;
    check_val("en_off_state", 32'(dbg_state), 32'(IDLE));
    check_val("en_off_stable", stable, 0);
    check_val("en_off_half", half_period, 53);
    check_val("en_off_level", level, 5);
    check_val("en_off_valid", meas_valid, 0);
    dco_in = ~dco_in;
    repeat (6) @(posedge clk);
    #1;
    check_val("idle_edge_valid", meas_valid, 0);
    en = 1'b1;
    @(posedge clk); #1;
    check_val("rearm_state", 32'(dbg_state), 32'(ARM));
    toggle_gap(11, 0, 0, 0, 0, 0);
    check_val("rearm_half_held", half_period, 53);
    toggle_gap(11, 1, 11, 0, 0, 0);

    // Asynchronous reset mid-count.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    dco_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("post_rst_state", 32'(dbg_state), 32'(ARM));
    toggle_gap(11, 0, 0, 0, 0, 0);
    toggle_gap(11, 1, 11, 0, 0, 0);
    toggle_gap(11, 1, 11, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
